// File: rtl/shift_sequencer_if.sv
// Command channel into the shift sequencer.
// Valid/ready handshake carrying one shift job.
interface shift_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_count;
  logic             cmd_fill;

  modport master (
    output cmd_valid,
    output cmd_data,
    output cmd_dir,
    output cmd_count,
    output cmd_fill,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_data,
    input  cmd_dir,
    input  cmd_count,
    input  cmd_fill,
    output cmd_ready
  );
endinterface

// File: rtl/shift_sequencer.sv
// Sequencer driving an 8-bit universal shift register.
// One load, N shifts, then hold; shadow copy gives the result.
module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             sync_reset,
  shift_sequencer_if.slave cmd,
  input  logic             stall,
  output logic [1:0]       sr_sel,
  output logic [WIDTH-1:0] sr_in,
  output logic             sr_rightshift,
  output logic             sr_leftshift,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_RIGHT = 2'b01;
  localparam logic [1:0] SEL_LEFT  = 2'b10;
  localparam logic [1:0] SEL_LOAD  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    FINISH
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] data_q;
  logic             dir_q;
  logic             fill_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] shadow;

  logic             take;
  logic [CNT_W-1:0] count_sat;
  logic [WIDTH-1:0] shift_r;
  logic [WIDTH-1:0] shift_l;

  assign take      = cmd.cmd_valid & cmd.cmd_ready;
  assign count_sat = (cmd.cmd_count > CNT_MAX) ? CNT_MAX
                                               : cmd.cmd_count;
  assign shift_r   = {fill_q, shadow[WIDTH-1:1]};
  assign shift_l   = {shadow[WIDTH-2:0], fill_q};

  // Control FSM; every output is registered and defaults to hold.
  always_ff @(posedge clk) begin
    if (!sync_reset) begin
      state         <= IDLE;
      cmd.cmd_ready <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      sr_sel        <= SEL_HOLD;
      sr_in         <= '0;
      sr_rightshift <= 1'b0;
      sr_leftshift  <= 1'b0;
      result        <= '0;
      cnt           <= '0;
      shadow        <= '0;
      data_q        <= '0;
      dir_q         <= 1'b0;
      fill_q        <= 1'b0;
    end else begin
      done          <= 1'b0;
      sr_sel        <= SEL_HOLD;
      sr_rightshift <= 1'b0;
      sr_leftshift  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (take) begin
            data_q        <= cmd.cmd_data;
            dir_q         <= cmd.cmd_dir;
            fill_q        <= cmd.cmd_fill;
            cnt           <= count_sat;
            cmd.cmd_ready <= 1'b0;
            busy          <= 1'b1;
            state         <= LOAD;
          end else begin
            cmd.cmd_ready <= 1'b1;
            busy          <= 1'b0;
          end
        end
        LOAD: begin
          sr_sel <= SEL_LOAD;
          sr_in  <= data_q;
          shadow <= data_q;
          state  <= (cnt == '0) ? FINISH : SHIFT;
        end
        SHIFT: begin
          if (!stall) begin
            if (dir_q) begin
              sr_sel       <= SEL_LEFT;
              sr_leftshift <= fill_q;
              shadow       <= shift_l;
            end else begin
              sr_sel        <= SEL_RIGHT;
              sr_rightshift <= fill_q;
              shadow        <= shift_r;
            end
            cnt <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
              state <= FINISH;
            end
          end
        end
        FINISH: begin
          done   <= 1'b1;
          result <= shadow;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer.
// Random jobs checked against an arithmetic model.
module tb_shift_sequencer;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          sync_reset = 1'b0;
  logic          stall = 1'b0;
  logic [1:0]    sr_sel;
  logic [W-1:0]  sr_in;
  logic          sr_rightshift;
  logic          sr_leftshift;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;

  shift_sequencer_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  shift_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk           (clk),
    .sync_reset    (sync_reset),
    .cmd           (bus),
    .stall         (stall),
    .sr_sel        (sr_sel),
    .sr_in         (sr_in),
    .sr_rightshift (sr_rightshift),
    .sr_leftshift  (sr_leftshift),
    .busy          (busy),
    .done          (done),
    .result        (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       dir;
    int         n;
    logic       fill;
    logic [7:0] res;
  } exp_t;

  exp_t q[$];

  int   total = 0;
  int   bad = 0;
  int   edges = 0;
  int   last_done_edge = 0;
  logic hs_pending = 1'b0;
  int   trk_n = 0;
  logic exp_done = 1'b0;
  logic exp_busy = 1'b0;
  logic stall_rand = 1'b0;
  logic stall_force = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [7:0] d,
                                       input logic dir, input int n,
                                       input logic f);
    logic [7:0] ones;
    logic [7:0] body;
    ones = 8'hFF;
    if (dir) begin
      body = d << n;
      ones = ~(ones << n);
    end else begin
      body = d >> n;
      ones = ~(ones >> n);
    end
    return f ? (body | ones) : body;
  endfunction

  initial forever begin
    @(posedge clk);
    edges++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    stall = stall_rand ? ($urandom_range(0, 3) == 0) : stall_force;
  end

  // Timeline model: load edge, one edge per unstalled shift, finish edge.
  initial begin : tracker
    int phase;
    int rem;
    phase = 0;
    rem = 0;
    forever begin
      @(posedge clk);
      if (!sync_reset) begin
        phase = 0;
        exp_done = 1'b0;
        exp_busy = 1'b0;
        q.delete();
      end else begin
        exp_done = 1'b0;
        case (phase)
          0: if (hs_pending) begin
            phase = 1;
            rem = trk_n;
            exp_busy = 1'b1;
          end
          1: phase = (rem == 0) ? 3 : 2;
          2: begin
            if (!stall) rem--;
            if (rem == 0) phase = 3;
          end
          3: begin
            exp_done = 1'b1;
            phase = 4;
          end
          default: begin
            exp_busy = 1'b0;
            phase = 0;
          end
        endcase
      end
    end
  end

  // Monitor: mirrors the external register and checks each done.
  initial begin : monitor
    logic [7:0] rm;
    int loads;
    int rs;
    int ls;
    int sbad;
    exp_t e;
    rm = '0;
    loads = 0;
    rs = 0;
    ls = 0;
    sbad = 0;
    forever begin
      @(negedge clk);
      if (!sync_reset) begin
        loads = 0;
        rs = 0;
        ls = 0;
        sbad = 0;
      end else begin
        case (sr_sel)
          2'b11: begin
            rm = sr_in;
            loads++;
          end
          2'b01: begin
            rm = {sr_rightshift, rm[7:1]};
            rs++;
            if (q.size() == 0 || sr_leftshift !== 1'b0 ||
                sr_rightshift !== q[0].fill) sbad++;
          end
          2'b10: begin
            rm = {rm[6:0], sr_leftshift};
            ls++;
            if (q.size() == 0 || sr_rightshift !== 1'b0 ||
                sr_leftshift !== q[0].fill) sbad++;
          end
          default: ;
        endcase
        chk("done", done, exp_done);
        chk("busy", busy, exp_busy);
        chk("ready", bus.cmd_ready, !exp_busy);
        if (done === 1'b1) begin
          last_done_edge = edges;
          if (q.size() == 0) begin
            chk("done_unexpected", 1, 0);
          end else begin
            e = q.pop_front();
            chk("result", result, e.res);
            chk("result_vs_reg", result, rm);
            chk("load_cycles", loads, 1);
            chk("right_shifts", rs, e.dir ? 0 : e.n);
            chk("left_shifts", ls, e.dir ? e.n : 0);
            chk("serial_bits", sbad, 0);
          end
          loads = 0;
          rs = 0;
          ls = 0;
          sbad = 0;
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic dir,
                      input logic [3:0] c, input logic f,
                      input bit keep, output int hs);
    exp_t e;
    bit ok;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_data = d;
    bus.cmd_dir = dir;
    bus.cmd_count = c;
    bus.cmd_fill = f;
    ok = 1'b0;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      ok = (bus.cmd_ready === 1'b1);
    end
    if (!ok) begin
      chk("handshake_timeout", 0, 1);
      bus.cmd_valid = 1'b0;
      hs = -1;
      return;
    end
    e.data = d;
    e.dir = dir;
    e.n = (c > 4'd8) ? 8 : int'(c);
    e.fill = f;
    e.res = model(d, dir, e.n, f);
    q.push_back(e);
    trk_n = e.n;
    hs_pending = 1'b1;
    @(posedge clk);
    #1;
    hs_pending = 1'b0;
    hs = edges;
    if (!keep) bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 400 && !ok; t++) begin
      @(negedge clk);
      ok = (q.size() == 0) && (bus.cmd_ready === 1'b1);
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int hs;
    int hs1;
    int hs2;
    bus.cmd_valid = 1'b0;
    bus.cmd_data = '0;
    bus.cmd_dir = 1'b0;
    bus.cmd_count = '0;
    bus.cmd_fill = 1'b0;
    sync_reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sync_reset = 1'b1;
    @(negedge clk);
    chk("rst_sel", sr_sel, 2'b00);
    chk("rst_in", sr_in, 8'h00);
    chk("rst_rs", sr_rightshift, 1'b0);
    chk("rst_ls", sr_leftshift, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ready", bus.cmd_ready, 1'b1);
    chk("rst_result", result, 8'h00);

    send(8'hB4, 1'b0, 4'd3, 1'b1, 1'b0, hs);
    wait_idle();
    chk("lat_b4", last_done_edge - hs, 5);

    send(8'h81, 1'b1, 4'd2, 1'b0, 1'b0, hs);
    wait_idle();
    chk("lat_81", last_done_edge - hs, 4);

    send(8'h3C, 1'b0, 4'd0, 1'b1, 1'b0, hs);
    wait_idle();
    chk("lat_3c", last_done_edge - hs, 2);

    send(8'h55, 1'b0, 4'd4, 1'b0, 1'b0, hs);
    @(negedge clk);
    @(negedge clk);
    stall_force = 1'b1;
    repeat (3) @(negedge clk);
    stall_force = 1'b0;
    wait_idle();
    chk("lat_stall", last_done_edge - hs, 9);

    send(8'hA5, 1'b0, 4'd5, 1'b0, 1'b0, hs);
    @(posedge clk);
    @(posedge clk);
    #1;
    sync_reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sync_reset = 1'b1;
    @(negedge clk);
    chk("midrst_sel", sr_sel, 2'b00);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_result", result, 8'h00);
    chk("midrst_done", done, 1'b0);
    wait_idle();

    send(8'h5A, 1'b1, 4'd12, 1'b1, 1'b1, hs1);
    send(8'h0F, 1'b0, 4'd2, 1'b0, 1'b0, hs2);
    wait_idle();
    chk("b2b_accept", hs2 - hs1, 12);

    stall_rand = 1'b1;
    repeat (150) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      send(8'($urandom), 1'($urandom), 4'($urandom_range(0, 12)),
           1'($urandom), $urandom_range(0, 3) == 0, hs);
    end
    bus.cmd_valid = 1'b0;
    stall_rand = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Command-driven controller sitting directly upstream of the 8-bit universal shift register.
- Accepts a command (data byte, direction, shift count, fill bit) over a valid/ready handshake.
- Issues one parallel-load cycle followed by N shift cycles on the register's sel / in / rightshift / leftshift inputs, then returns the register to hold.
- Keeps an internal shadow copy of the register contents and reports it with a done pulse, so software and bench never need to read the register's out directly.

Parameters:
WIDTH, 8, data width; must match the driven shift register.
CNT_W, 4, width of the shift-count field; legal counts are 0..WIDTH.

Ports:
clk  input  1  rising-edge clock shared with the shift register
sync_reset  input  1  synchronous reset, active-low (0 = reset on next rising clk edge)
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command this cycle
cmd_data  input  WIDTH  byte to parallel-load
cmd_dir  input  1  0 = shift right (toward bit 0), 1 = shift left (toward bit WIDTH-1)
cmd_count  input  CNT_W  number of shift cycles after the load
cmd_fill  input  1  serial bit injected on each shift
stall  input  1  freezes shifting (register held) while high
sr_sel  output  2  to register sel: 00 hold, 01 shift right, 10 shift left, 11 parallel load
sr_in  output  WIDTH  to register parallel input
sr_rightshift  output  1  serial input entering bit WIDTH-1 on a right shift
sr_leftshift  output  1  serial input entering bit 0 on a left shift
busy  output  1  command in progress
done  output  1  one-cycle pulse when a command completes
result  output  WIDTH  shadow of the register contents, valid from done onward

Behaviour:
- Reset (sync_reset==0 at a clk edge), values on that edge:
  - state=IDLE; cmd_ready=1; busy=0; done=0.
  - sr_sel=00; sr_in=0; sr_rightshift=0; sr_leftshift=0; result=0; count register=0.
- Reset overrides everything, including a command in flight. The register is left at hold; the partial shift is abandoned and no done pulse is issued.
- States: IDLE, LOAD, SHIFT, FINISH.
- IDLE:
  - cmd_ready=1, sr_sel=00.
  - A handshake (cmd_valid & cmd_ready) latches data, dir, count (saturated to WIDTH if greater) and fill, then moves to LOAD.
  - cmd_ready is registered: it deasserts on the cycle after the handshake. A command presented while busy is held off and not dropped.
- LOAD (exactly 1 cycle):
  - sr_sel=11, sr_in=latched data; shadow <= data.
  - If count==0, go to FINISH; else go to SHIFT with the remaining count = count.
- SHIFT:
  - If stall==1: sr_sel=00, nothing changes.
  - Else:
    - sr_sel = 01 if dir==0, 10 if dir==1.
    - The fill bit drives the active serial input; the other serial input is driven 0.
    - shadow shifts identically: right gives {fill, shadow[WIDTH-1:1]}, left gives {shadow[WIDTH-2:0], fill}.
    - Remaining count decrements; when it reaches 1 and the shift is taken, go to FINISH.
- FINISH (1 cycle):
  - sr_sel=00; result <= shadow; done=1.
  - Go to IDLE with cmd_ready=1 on the next cycle.
- busy=1 in LOAD, SHIFT and FINISH; 0 in IDLE.
- done is high only in FINISH.
- result holds its value until the next FINISH or reset.
- Latency, handshake to done: 2+N cycles with no stall; each stalled cycle adds 1.
- stall is ignored in IDLE, LOAD and FINISH.
- The sr_* outputs are registered, so the register's state always equals the shadow one cycle after each sequencer edge.
- count > WIDTH saturates to WIDTH; the result is then all fill bits.

Test Plan:
- Reset with sync_reset=0 for 2 cycles mid-SHIFT (data 0xA5, right, count 5) -> after the edge: IDLE, sr_sel=00, busy=0, result=0x00, no done pulse.
- Command data=0xB4, dir=0, count=3, fill=1 -> sr_sel sequence 11,01,01,01,00; done on cycle 5 after the handshake; result=0xF6.
- Command data=0x81, dir=1, count=2, fill=0 -> sr_sel 11,10,10,00; result=0x04; sr_rightshift stays 0 throughout.
- Command data=0x3C, count=0 -> one load cycle, then done on the next cycle; result=0x3C.
- Command data=0x55, dir=0, count=4, fill=0, with stall=1 for 3 cycles during SHIFT -> sr_sel=00 during the stalled cycles; done 9 cycles after the handshake; result=0x05.
- Back-to-back commands with cmd_valid held high -> second command accepted only on the cycle cmd_ready returns after the first done; count=12 is saturated to 8; fill=1 gives result=0xFF.
